// File: rtl/minaret_mem_arbiter.sv
// minaret_mem_arbiter: shares one single-ported memory between imem and dmem, one access outstanding (round robin under MINARET_ARB_ROUND_ROBIN_EN).
// Latency: request sampled in IDLE -> mem_valid next cycle; mem_ready -> requester ready next cycle (3 cycles minimum).
// Backpressure: requesters hold valid until their one-cycle ready; a hung access aborts after TIMEOUT busy cycles with ERR_RDATA.
module minaret_mem_arbiter #(
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_valid,
  output logic        imem_ready,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  input  logic        dmem_valid,
  output logic        dmem_ready,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_rmask,
  output logic [31:0] dmem_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] to_cnt;
  logic        grant_d, grant_i;
  logic        busy, timeout_hit, complete;
  logic [31:0] done_rdata;
  logic        rmask_unused;

  // The core applies rmask itself; read data is forwarded unmasked.
  assign rmask_unused = ^dmem_rmask;

`ifdef MINARET_ARB_ROUND_ROBIN_EN
  logic rr_prefer_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_prefer_d <= 1'b1;
    end else if (complete) begin
      rr_prefer_d <= (state == BUSY_I);
    end
  end

  assign grant_d = dmem_valid && (!imem_valid || rr_prefer_d);
`else
  assign grant_d = dmem_valid;
`endif
  assign grant_i = imem_valid && !grant_d;

  assign busy        = (state == BUSY_I) || (state == BUSY_D);
  assign timeout_hit = busy && !mem_ready && (to_cnt == TO_LAST);
  assign complete    = busy && (mem_ready || timeout_hit);
  assign done_rdata  = mem_ready ? mem_rdata : ERR_RDATA;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt = BUSY_D;
        end else if (grant_i) begin
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (complete) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= '0;
      mem_wdata  <= '0;
      imem_ready <= 1'b0;
      dmem_ready <= 1'b0;
      imem_rdata <= '0;
      dmem_rdata <= '0;
      bus_err    <= 1'b0;
      to_cnt     <= '0;
    end else begin
      // Ready/rdata are single-cycle pulses; zero unless completing.
      imem_ready <= 1'b0;
      dmem_ready <= 1'b0;
      imem_rdata <= '0;
      dmem_rdata <= '0;
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            mem_valid <= 1'b1;
            mem_addr  <= dmem_addr;
            mem_wstrb <= dmem_wmask;
            mem_wdata <= dmem_wdata;
          end else if (grant_i) begin
            mem_valid <= 1'b1;
            mem_addr  <= imem_addr;
            mem_wstrb <= '0;
            mem_wdata <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          to_cnt <= to_cnt + 16'd1;
          if (complete) begin
            mem_valid <= 1'b0;
            if (state == BUSY_I) begin
              imem_ready <= 1'b1;
              imem_rdata <= done_rdata;
            end else begin
              dmem_ready <= 1'b1;
              dmem_rdata <= done_rdata;
            end
          end
          if (timeout_hit) begin
            bus_err <= 1'b1;
          end
        end
        DONE:    to_cnt <= '0;
        default: to_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_minaret_mem_arbiter.sv
// Randomised bench for minaret_mem_arbiter: transaction-level reference model predicts grants, completion edges,
// read data, timeouts and bus_err from the latency rules; every output is compared once per cycle.
module tb_minaret_mem_arbiter;

  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
`ifdef MINARET_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        imem_valid, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_valid, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wmask, dmem_rmask;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        bus_err;

  minaret_mem_arbiter #(.TIMEOUT(T), .ERR_RDATA(ERR)) dut (
    .clk(clk), .reset(reset),
    .imem_valid(imem_valid), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rmask(dmem_rmask), .dmem_rdata(dmem_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one descriptor for the access in flight plus the expected pulse outputs.
  int          edge_n, free_edge, n_done;
  bit          out_act, out_d_who, out_to, pref_d, berr_exp, pair_sent, win_d;
  int          out_s, out_dly, out_f;
  logic [31:0] out_addr, out_wdata, out_rd;
  logic [3:0]  out_wstrb;
  bit          exp_ir, exp_dr, exp_rd_chk;
  logic [31:0] exp_rdv;
  int          d_script[$];

  initial begin
    reset = 1'b1;
    imem_valid = 0; imem_addr = 0;
    dmem_valid = 0; dmem_addr = 0; dmem_wmask = 0; dmem_wdata = 0; dmem_rmask = 0;
    mem_ready = 0; mem_rdata = 0;
    edge_n = 0; free_edge = 1 << 30; n_done = 0;
    out_act = 0; out_d_who = 0; out_to = 0; pref_d = 1; berr_exp = 0; pair_sent = 0;
    out_s = 0; out_dly = 0; out_f = 0; out_addr = 0; out_wdata = 0; out_rd = 0; out_wstrb = 0;
    exp_ir = 0; exp_dr = 0; exp_rd_chk = 0; exp_rdv = 0;
    // Opening delays: fetch, then the dmem/imem pair, then wait states, boundary and timeout.
    d_script = '{1, 1, 0, 5, 7, 8, 20, 0};

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      edge_n++;
      #1;
      exp_ir = 0; exp_dr = 0; exp_rd_chk = 0; exp_rdv = 0;
      if (reset) begin
        out_act = 0; free_edge = edge_n + 1; berr_exp = 0; pref_d = 1;
      end else if (out_act && edge_n == out_f) begin
        exp_rdv    = out_to ? ERR : out_rd;
        exp_rd_chk = (out_wstrb == 4'h0);
        if (out_d_who) exp_dr = 1; else exp_ir = 1;
        if (out_to) berr_exp = 1;
        pref_d  = !out_d_who;
        out_act = 0;
        n_done++;
        free_edge = edge_n + 2;
      end else if (!out_act && edge_n >= free_edge && (imem_valid || dmem_valid)) begin
        win_d     = dmem_valid && (!imem_valid || pref_d || !RR);
        out_act   = 1;
        out_s     = edge_n;
        out_d_who = win_d;
        out_addr  = win_d ? dmem_addr : imem_addr;
        out_wstrb = win_d ? dmem_wmask : 4'h0;
        out_wdata = win_d ? dmem_wdata : 32'h0;
        out_dly   = (d_script.size() > 0) ? d_script.pop_front() : int'($urandom_range(0, 10));
        out_to    = out_dly > T - 1;
        out_f     = out_s + ((out_dly < T - 1) ? out_dly : T - 1) + 1;
        out_rd    = (n_done == 0) ? 32'h0000_0013 : $urandom;
      end

      if (cyc == 0) begin
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
      end
      check("mem_valid", mem_valid, out_act);
      if (out_act) begin
        check("mem_addr", mem_addr, out_addr);
        check("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, out_wstrb});
        check("mem_wdata", mem_wdata, out_wdata);
      end
      check("imem_ready", imem_ready, exp_ir);
      check("dmem_ready", dmem_ready, exp_dr);
      if (exp_ir) check("imem_rdata", imem_rdata, exp_rdv);
      else        check("imem_rdata_idle", imem_rdata, 32'h0);
      if (exp_dr) begin
        if (exp_rd_chk) check("dmem_rdata", dmem_rdata, exp_rdv);
      end else begin
        check("dmem_rdata_idle", dmem_rdata, 32'h0);
      end
      check("bus_err", bus_err, berr_exp);

      // Drive the next cycle: reset, requesters, then the memory responder.
      reset = (cyc < 1) || (n_done >= 3 && out_act && $urandom_range(0, 29) == 0);
      if (reset) begin
        imem_valid = 0;
        dmem_valid = 0;
      end else begin
        if (exp_ir) imem_valid = 0;
        if (exp_dr) dmem_valid = 0;
        if (cyc == 1) begin
          imem_valid = 1; imem_addr = 32'h100;
        end else if (n_done == 1 && !pair_sent) begin
          pair_sent  = 1;
          imem_valid = 1; imem_addr = 32'h200;
          dmem_valid = 1; dmem_addr = 32'h1000_0000; dmem_wmask = 4'hF; dmem_wdata = 32'h41; dmem_rmask = 4'h0;
        end else if (n_done >= 3) begin
          if (!imem_valid && $urandom_range(0, 2) == 0) begin
            imem_valid = 1;
            imem_addr  = $urandom & 32'hFFFF_FFFC;
          end
          if (!dmem_valid && $urandom_range(0, 2) == 0) begin
            dmem_valid = 1;
            dmem_addr  = $urandom;
            dmem_wmask = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            dmem_wdata = $urandom;
            dmem_rmask = 4'($urandom_range(0, 15));
          end
        end
      end
      if (!reset && out_act && !out_to && (edge_n - out_s) == out_dly) begin
        mem_ready = 1;
        mem_rdata = out_rd;
      end else begin
        mem_ready = 0;
        mem_rdata = $urandom;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/minaret_mem_arbiter.md
Name: minaret_mem_arbiter

Overview:
- Shares one single-ported memory between the minaret core's instruction port (imem) and data port (dmem).
- Sits between the core and memory/MMIO in both the SoC top and the simulation bench.
- Serialises requests: at most one downstream transaction outstanding.
- Provides a per-transaction timeout that completes a hung access with an error pattern and raises a sticky bus error.

Parameters:
- TIMEOUT, 1024: cycles to wait for mem_ready before aborting a transaction; legal range 2..65535.
- ERR_RDATA, 32'hDEAD_BEEF: rdata returned on a timed-out read.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_valid  in  1  instruction fetch request, held until imem_ready.
- imem_ready  out  1  one-cycle completion pulse for imem.
- imem_addr  in  32  fetch byte address, stable while imem_valid.
- imem_rdata  out  32  fetch data, valid only while imem_ready=1.
- dmem_valid  in  1  data request, held until dmem_ready.
- dmem_ready  out  1  one-cycle completion pulse for dmem.
- dmem_addr  in  32  data byte address.
- dmem_wmask  in  4  byte write strobes; nonzero means write.
- dmem_wdata  in  32  write data.
- dmem_rmask  in  4  byte read mask; used when wmask=0.
- dmem_rdata  out  32  load data, valid only while dmem_ready=1.
- mem_valid  out  1  downstream request, held until mem_ready.
- mem_ready  in  1  downstream completion, one cycle.
- mem_addr  out  32  downstream address.
- mem_wstrb  out  4  downstream write strobes; 0 for reads.
- mem_wdata  out  32  downstream write data.
- mem_rdata  in  32  downstream read data, valid with mem_ready.
- bus_err  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, timeout counter 0, round-robin pointer selecting dmem.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE:
  - Sample imem_valid and dmem_valid.
  - Default policy is fixed priority: dmem beats imem.
  - On a grant, register mem_addr/mem_wstrb/mem_wdata from the winner; for imem, wstrb=0 and wdata=0.
  - Set mem_valid=1 next cycle and go to BUSY_I or BUSY_D.
  - If neither requester is valid, stay in IDLE.
- BUSY_x:
  - Hold mem_valid and all mem_* outputs stable.
  - When mem_ready=1: register mem_rdata into the winner's rdata register, drop mem_valid next cycle, go to DONE.
  - Timeout counter increments each BUSY cycle.
  - If the count reaches TIMEOUT-1 without mem_ready: drop mem_valid, load ERR_RDATA into the rdata register, set bus_err, go to DONE.
  - If mem_ready arrives in the same cycle the count reaches TIMEOUT-1, it wins: normal completion, no error.
- DONE:
  - Assert the winner's ready for exactly one cycle with the registered rdata; the other ready stays 0.
  - Clear the timeout counter and return to IDLE.
  - A request still asserted during DONE is never re-granted in DONE; it is re-sampled only in IDLE.
- Latency:
  - Request seen in IDLE at cycle N gives mem_valid=1 at N+1.
  - mem_ready at cycle M gives xmem_ready=1 at M+1.
  - Minimum 3 cycles request-to-ready (zero-wait memory).
- Reads versus writes:
  - On a read, mem_rdata is passed unmasked; the core applies rmask.
  - On a write, the captured rdata is don't-care, but ready still pulses.
- Requester rdata outputs are 0 whenever their ready is 0.
- Reset mid-transaction: FSM returns to IDLE next cycle and mem_valid drops. The outstanding downstream access is abandoned, and no ready pulse is issued.
- Requester protocol violations (valid dropped before ready) are not checked. The in-flight transaction completes and the ready pulse is still issued.

Optional Feature:
- Macro: MINARET_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit pointer selects the preferred requester when both are valid in IDLE.
  - After each completion, the pointer moves to the requester that did not just complete.
  - With continuous dual requests, grants strictly alternate.
- Undefined: fixed dmem priority; the pointer register is not synthesised.

Test Plan:
- Single fetch: imem_valid=1, imem_addr=0x100; memory returns mem_ready one cycle after mem_valid with rdata 0x00000013 -> mem_addr=0x100, mem_wstrb=0, imem_ready pulse at cycle 3 with imem_rdata=0x00000013, dmem_ready stays 0.
- Simultaneous requests: imem at 0x200 and dmem write at 0x1000_0000 (wmask=0xF, wdata=0x41) issued together -> dmem granted first (mem_wstrb=0xF, mem_wdata=0x41), then imem. With MINARET_ARB_ROUND_ROBIN_EN and both held, grant order is D,I,D,I.
- Wait states: mem_ready delayed 5 cycles -> mem_* outputs stay stable throughout, ready pulse exactly 1 cycle, no bus_err.
- Timeout: TIMEOUT=8, mem_ready never asserted on a dmem read -> mem_valid drops after 8 BUSY cycles, dmem_ready pulse with dmem_rdata=0xDEADBEEF, bus_err=1 and remains 1. Next request is serviced normally.
- Timeout boundary: TIMEOUT=8, mem_ready asserted on the final BUSY cycle (count 7) -> normal completion, bus_err stays 0.
- Reset mid-operation: reset asserted while in BUSY_I -> next cycle mem_valid=0, imem_ready never pulses. After release, a new dmem request completes with normal latency.
